// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
package sub_serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sub_state_e;

  localparam int unsigned SUB_SERIAL_WIDTH = 6;

  // Largest positive two's-complement value of a w-bit word, zero-extended to 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned w);
    logic [31:0] m;
    m = '1;
    return m >> (33 - w);
  endfunction

  // Most negative two's-complement value of a w-bit word; only the low w bits are meaningful.
  function automatic logic [31:0] sat_min(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = x - y - borrow_in.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  always_comb begin
    d          = x ^ y ^ borrow_in;
    borrow_out = (~x & y) | (~x & borrow_in) | (y & borrow_in);
  end

endmodule

// File: rtl/sub_serial_top.sv
// Bit-serial signed subtractor diff = a - b - bin, LSB first, WIDTH cycles per operation.
// Optional saturating result when SUB_SERIAL_SAT_EN is defined.
module sub_serial_top
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

`ifdef SUB_SERIAL_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
  logic a_neg;
`endif

  sub_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;

  logic             d_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;

  full_sub u_full_sub (
    .x          (a_sr[0]),
    .y          (b_sr[0]),
    .borrow_in  (borrow),
    .d          (d_bit),
    .borrow_out (borrow_nxt)
  );

  // On the final bit, 'borrow' is the borrow into the MSB and borrow_nxt the borrow out of it.
  always_comb begin
    res_nxt = {d_bit, res_sr[WIDTH-1:1]};
    ovf_nxt = borrow ^ borrow_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
`ifdef SUB_SERIAL_SAT_EN
      a_neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SUB_SERIAL_SAT_EN
            a_neg  <= a[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res_sr <= res_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SUB_SERIAL_SAT_EN
            diff <= ovf_nxt ? (a_neg ? SAT_MIN : SAT_MAX) : res_nxt;
`else
            diff <= res_nxt;
`endif
            overflow <= ovf_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_top.sv
// Scoreboard bench for sub_serial_top: integer reference model, directed cases,
// exhaustive operand sweep with random mid-operation start pulses, random ops.
module tb_sub_serial_top;

  localparam int W    = 6;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef struct {
    logic [W-1:0] diff;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         overflow;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  sub_serial_top #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer subtraction, range test, modulo wrap or clamp.
  function automatic exp_t model(input int av, input int bv, input int bi, input int done_cyc);
    exp_t e;
    int   r;
    r     = av - bv - bi;
    e.ovf = (r > MAXV) || (r < MINV);
    e.diff = W'(r);
`ifdef SUB_SERIAL_SAT_EN
    if (e.ovf) e.diff = (av < 0) ? W'(MINV) : W'(MAXV);
`endif
    e.cyc = done_cyc;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_busy_exclusive", busy, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("diff", diff, e.diff);
        chk("overflow", overflow, e.ovf);
      end
    end
  end

  // Starts one op at the next negedge and returns after its final edge, so a
  // following call lands in the done cycle (back-to-back).
  task automatic issue(input int av, input int bv, input int bi, input bit record, input bit garbage);
    int k;
    k = (W > 2) ? $urandom_range(W - 2, 0) : 0;
    @(negedge clk);
    a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
    if (record) exp_q.push_back(model(av, bv, bi, cyc + 1 + W));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
      if (garbage && i == k) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end else begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    // Reset held two cycles with start asserted.
    rst = 1'b1; start = 1'b1; a = W'(5); b = W'(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    start = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("post_reset");

    issue(5, 3, 0, 1, 0);
    issue(0, 0, 1, 1, 0);
    issue(-32, 1, 0, 1, 0);
    issue(-32, 0, 1, 1, 0);
    issue(31, -1, 0, 1, 0);
    issue(-1, 31, 0, 1, 0);
    issue(7, -9, 1, 1, 1);
    issue(-20, 13, 0, 1, 1);

    // Reset at cycle 3 of an operation: no done, outputs cleared.
    issue(1, 2, 0, 1, 0);
    @(negedge clk);
    a = W'(9); b = W'(4); bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("abort");
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done_pending", exp_q.size(), 0);
    check_outputs_zero("abort_after");

    // Exhaustive sweep with random ignored starts mid-operation.
    for (int bi = 0; bi < 2; bi++)
      for (int av = MINV; av <= MAXV; av++)
        for (int bv = MINV; bv <= MAXV; bv++)
          issue(av, bv, bi, 1, ($urandom_range(3, 0) == 0));

    for (int n = 0; n < 200; n++)
      issue($urandom_range(2 * MAXV + 1, 0) + MINV, $urandom_range(2 * MAXV + 1, 0) + MINV,
            $urandom_range(1, 0), 1, 1);

    repeat (W + 3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time bound so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
